// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : handshaked WIDTH-bit ALU with iterative unsigned MUL and DIV      |
// | rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   Ain,
  input  logic [WIDTH-1:0]   Bin,
  input  logic [2:0]         mode,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               div_by_zero
);

  localparam int               c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

  localparam logic [2:0] c_add = 3'd0;
  localparam logic [2:0] c_sub = 3'd1;
  localparam logic [2:0] c_and = 3'd2;
  localparam logic [2:0] c_or  = 3'd3;
  localparam logic [2:0] c_xor = 3'd4;
  localparam logic [2:0] c_mul = 3'd5;
  localparam logic [2:0] c_div = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_cw-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_hi, r_lo, r_b;
  logic              r_is_div;

  logic              w_accept, w_multi, w_load;
  logic [2*WIDTH-1:0] w_a, w_b, w_add, w_sub, w_single, w_res_nxt;
  logic              w_single_carry, w_carry_nxt, w_dbz_nxt;

  // iteration datapath: {r_hi, r_lo} is the product (MUL) or {remainder, quotient} (DIV)
  logic [WIDTH:0]    w_mul_sum, w_div_shift;
  logic              w_div_ge;
  logic [WIDTH-1:0]  w_step_hi, w_step_lo;

  assign in_ready  = (r_state != ST_RUN);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_multi   = (mode == c_mul) || (mode == c_div);

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});

  always_comb begin
    w_step_hi = w_mul_sum[WIDTH:1];
    w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_step_hi = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_b}) : w_div_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  assign w_a   = {{WIDTH{1'b0}}, Ain};
  assign w_b   = {{WIDTH{1'b0}}, Bin};
  assign w_add = w_a + w_b;
  assign w_sub = w_a - w_b;

  always_comb begin
    w_single       = '0;
    w_single_carry = 1'b0;
    case (mode)
      c_add: begin w_single = w_add; w_single_carry = w_add[WIDTH]; end
      c_sub: begin w_single = w_sub; w_single_carry = (Ain < Bin);  end
      c_and: w_single = w_a & w_b;
      c_or:  w_single = w_a | w_b;
      c_xor: w_single = w_a ^ w_b;
      default: w_single = {{(2*WIDTH-3){1'b0}}, (Ain > Bin), (Ain == Bin), (Ain < Bin)};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res_nxt   = w_single;
    w_carry_nxt = w_single_carry;
    w_dbz_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_multi ? ST_RUN : ST_DONE;
          w_load      = !w_multi;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_last) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res_nxt   = {w_step_hi, w_step_lo};
          w_carry_nxt = 1'b0;
          w_dbz_nxt   = r_is_div && (r_b == '0);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= Ain;
      r_b      <= Bin;
      r_is_div <= (mode == c_div);
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + c_cw'(1);
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_load) begin
      result      <= w_res_nxt;
      carry       <= w_carry_nxt;
      zero        <= (w_res_nxt == '0);
      div_by_zero <= w_dbz_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_seq : directed self-checking bench for alu_seq at WIDTH=8 and 16     |
// | rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  Ain = '0, Bin = '0;
  logic [2:0]  mode = '0;
  logic        out_valid, carry, zero, div_by_zero;
  logic [15:0] result;

  logic        v16 = 1'b0, rdy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  m16 = '0;
  logic        ov16, cy16, z16, dz16;
  logic [31:0] res16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .mode(mode), .out_valid(out_valid), .result(result),
    .carry(carry), .zero(zero), .div_by_zero(div_by_zero)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .Ain(a16), .Bin(b16), .mode(m16), .out_valid(ov16), .result(res16),
    .carry(cy16), .zero(z16), .div_by_zero(dz16)
  );

  // drive one op into the 8-bit DUT; lat = accept edge to out_valid edge, -1 on timeout
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                        output int lat);
    @(negedge clk);
    Ain = a; Bin = b; mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                          output int lat);
    @(negedge clk);
    a16 = a; b16 = b; m16 = m; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!ov16) lat = -1;
  endtask

  task automatic test_reset;
    logic seen_ov, seen_busy;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if ({carry, zero, div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {carry, zero, div_by_zero}); end
    total++; if ({rdy16, ov16, res16} !== {2'b10, 32'h0}) begin bad++; $display("FAIL reset_w16 got=%b %b %h want=1 0 0", rdy16, ov16, res16); end
    seen_ov = 1'b0; seen_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_ov   |= out_valid;
      seen_busy |= !in_ready;
    end
    total++; if ({seen_ov, seen_busy} !== 2'b00) begin bad++; $display("FAIL idle_hold got=%b want=00", {seen_ov, seen_busy}); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    Ain = 8'h33; Bin = 8'h44; mode = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, result, carry} !== {1'b1, 16'h0077, 1'b0}) begin bad++; $display("FAIL b2b_add got=%b %h %b want=1 0077 0", out_valid, result, carry); end
    mode = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({out_valid, result, carry} !== {1'b1, 16'hFFEF, 1'b1}) begin bad++; $display("FAIL b2b_sub got=%b %h %b want=1 ffef 1", out_valid, result, carry); end
    @(negedge clk);
    total++; if ({out_valid, in_ready, result} !== {2'b01, 16'hFFEF}) begin bad++; $display("FAIL b2b_hold got=%b %b %h want=0 1 ffef", out_valid, in_ready, result); end
  endtask

  task automatic test_mul;
    int lat, busy;
    @(negedge clk);
    Ain = 8'h33; Bin = 8'h44; mode = 3'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      if (lat == 3) begin Ain = 8'hFF; Bin = 8'hFF; mode = 3'd0; in_valid = 1'b1; end
      if (lat == 4) in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    total++; if (lat !== 9) begin bad++; $display("FAIL mul_latency got=%0d want=9", lat); end
    total++; if (busy !== 8) begin bad++; $display("FAIL mul_busy got=%0d want=8", busy); end
    total++; if ({result, zero, carry} !== {16'h0D8C, 2'b00}) begin bad++; $display("FAIL mul_result got=%h %b %b want=0d8c 0 0", result, zero, carry); end
    @(negedge clk);
    total++; if ({out_valid, result} !== {1'b0, 16'h0D8C}) begin bad++; $display("FAIL mul_no_extra got=%b %h want=0 0d8c", out_valid, result); end
  endtask

  task automatic test_div;
    int lat;
    run_op(8'h44, 8'h33, 3'd6, lat);
    total++; if ({lat == 9, result, div_by_zero, zero} !== {1'b1, 16'h1101, 2'b00}) begin bad++; $display("FAIL div_basic got=%0d %h %b %b want=9 1101 0 0", lat, result, div_by_zero, zero); end
    run_op(8'h44, 8'h00, 3'd6, lat);
    total++; if ({lat == 9, result, div_by_zero, zero} !== {1'b1, 16'h44FF, 2'b10}) begin bad++; $display("FAIL div_zero got=%0d %h %b %b want=9 44ff 1 0", lat, result, div_by_zero, zero); end
    run_op(8'h00, 8'h05, 3'd6, lat);
    total++; if ({result, div_by_zero, zero} !== {16'h0000, 2'b01}) begin bad++; $display("FAIL div_zero_num got=%h %b %b want=0000 0 1", result, div_by_zero, zero); end
    run_op(8'hFF, 8'h10, 3'd6, lat);
    total++; if (result !== 16'h0F0F) begin bad++; $display("FAIL div_ff got=%h want=0f0f", result); end
  endtask

  task automatic test_logic_cmp;
    int lat;
    run_op(8'h33, 8'h44, 3'd7, lat);
    total++; if ({lat, result, carry} !== {32'd1, 16'h0001, 1'b0}) begin bad++; $display("FAIL cmp_lt got=%0d %h %b want=1 0001 0", lat, result, carry); end
    run_op(8'h5A, 8'h5A, 3'd7, lat);
    total++; if (result !== 16'h0002) begin bad++; $display("FAIL cmp_eq got=%h want=0002", result); end
    run_op(8'h80, 8'h7F, 3'd7, lat);
    total++; if (result !== 16'h0004) begin bad++; $display("FAIL cmp_gt got=%h want=0004", result); end
    run_op(8'h33, 8'h44, 3'd2, lat);
    total++; if ({result, zero} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL and got=%h %b want=0000 1", result, zero); end
    run_op(8'h33, 8'h44, 3'd4, lat);
    total++; if ({result, zero} !== {16'h0077, 1'b0}) begin bad++; $display("FAIL xor got=%h %b want=0077 0", result, zero); end
    run_op(8'hF0, 8'h3C, 3'd3, lat);
    total++; if (result !== 16'h00FC) begin bad++; $display("FAIL or got=%h want=00fc", result); end
    run_op(8'h10, 8'h20, 3'd1, lat);
    total++; if ({result, carry} !== {16'hFFF0, 1'b1}) begin bad++; $display("FAIL sub_borrow got=%h %b want=fff0 1", result, carry); end
    run_op(8'h0F, 8'h0F, 3'd2, lat);
    total++; if ({result, carry} !== {16'h000F, 1'b0}) begin bad++; $display("FAIL carry_clear got=%h %b want=000f 0", result, carry); end
    run_op(8'h44, 8'h44, 3'd1, lat);
    total++; if ({result, carry, zero} !== {16'h0000, 2'b01}) begin bad++; $display("FAIL sub_equal got=%h %b %b want=0000 0 1", result, carry, zero); end
  endtask

  task automatic test_reset_mid_run;
    int  lat;
    logic seen;
    @(negedge clk);
    Ain = 8'h33; Bin = 8'h44; mode = 3'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({in_ready, out_valid, result, carry, zero} !== {2'b10, 16'h0, 2'b00}) begin bad++; $display("FAIL async_reset got=%b %b %h %b %b want=1 0 0000 0 0", in_ready, out_valid, result, carry, zero); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= out_valid; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); seen |= out_valid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mul_discarded got=%b want=0", seen); end
    run_op(8'h01, 8'hFF, 3'd0, lat);
    total++; if ({lat, result, carry} !== {32'd1, 16'h0100, 1'b1}) begin bad++; $display("FAIL add_after_reset got=%0d %h %b want=1 0100 1", lat, result, carry); end
  endtask

  task automatic test_wide;
    int lat;
    run_op16(16'hFFFF, 16'hFFFF, 3'd5, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL w16_mul_latency got=%0d want=17", lat); end
    total++; if ({res16, cy16, z16} !== {32'hFFFE0001, 2'b00}) begin bad++; $display("FAIL w16_mul got=%h %b %b want=fffe0001 0 0", res16, cy16, z16); end
    run_op16(16'h1234, 16'h0010, 3'd6, lat);
    total++; if ({lat, res16, dz16} !== {32'd17, 32'h00040123, 1'b0}) begin bad++; $display("FAIL w16_div got=%0d %h %b want=17 00040123 0", lat, res16, dz16); end
    run_op16(16'hFFFF, 16'h0001, 3'd0, lat);
    total++; if ({lat, res16, cy16} !== {32'd1, 32'h00010000, 1'b1}) begin bad++; $display("FAIL w16_add got=%0d %h %b want=1 00010000 1", lat, res16, cy16); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_logic_cmp();
    test_reset_mid_run();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
